sprite_compositor: RTL and testbench

Final pixel stage of the display pipeline: takes the per-sprite 12-bit pixel streams produced by the sprite pixel blocks (e.g. digit sprites) and merges them by fixed priority over a background colour. It delays the timing generator's hsync/vsync/blank to match the sprite pipeline latency, and drives the registered VGA output. It also produces a frame-start pulse, a frame counter, and a per-frame shadowed layer-enable mask for tear-free sprite switching.

---
 rtl/sprite_compositor.sv | 111 +++++++++++
 tb/tb_sprite_compositor.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/sprite_compositor.sv
// sprite_compositor
// Final pixel stage of the display pipeline. It merges the per-sprite 12-bit
// pixel streams by fixed priority (layer 0 highest) over a background colour.
// It delays hsync/vsync/blank to match the sprite pipeline latency and drives
// the registered VGA outputs. It also produces a frame-start pulse, a frame
// counter, and a layer-enable mask that is shadowed once per frame.
//
// Ports:
//   pixel_clk_in     pixel clock (only clock)
//   rst_n_in         synchronous active-low reset
//   hsync_in         active-low hsync from the timing generator
//   vsync_in         active-low vsync from the timing generator
//   blank_in         high outside the active area
//   layer_pixels_in  layer i at [12i+11:12i] as {R,G,B}; 12'h000 = transparent
//   layer_enable_in  requested layer mask, captured at frame start
//   hsync_out        delayed, registered hsync
//   vsync_out        delayed, registered vsync
//   blank_out        delayed, registered blank
//   rgb_out          composed, registered pixel
//   frame_start_out  one-cycle pulse in the first cycle vsync_out is low
//   frame_count_out  frames started since reset (wraps)
module sprite_compositor #(
  parameter int unsigned NUM_LAYERS = 4,
  parameter int unsigned SYNC_DELAY = 2,
  parameter logic [11:0] BG_COLOR   = 12'h000
) (
  input  logic                       pixel_clk_in,
  input  logic                       rst_n_in,
  input  logic                       hsync_in,
  input  logic                       vsync_in,
  input  logic                       blank_in,
  input  logic [12*NUM_LAYERS-1:0]   layer_pixels_in,
  input  logic [NUM_LAYERS-1:0]      layer_enable_in,
  output logic                       hsync_out,
  output logic                       vsync_out,
  output logic                       blank_out,
  output logic [11:0]                rgb_out,
  output logic                       frame_start_out,
  output logic [15:0]                frame_count_out
);

  logic                  d_hs;
  logic                  d_vs;
  logic                  d_bl;
  logic [NUM_LAYERS-1:0] mask;
  logic [11:0]           comp_rgb;
  logic                  frame_edge;

  // Sync delay line; each stage carries {hsync, vsync, blank}.
  if (SYNC_DELAY == 0) begin : g_nodelay
    assign {d_hs, d_vs, d_bl} = {hsync_in, vsync_in, blank_in};
  end else begin : g_delay
    for (genvar g = 0; g < SYNC_DELAY; g++) begin : g_stage
      logic [2:0] q;
      if (g == 0) begin : g_first
        always_ff @(posedge pixel_clk_in) begin
          if (!rst_n_in) q <= '1;
          else           q <= {hsync_in, vsync_in, blank_in};
        end
      end else begin : g_next
        always_ff @(posedge pixel_clk_in) begin
          if (!rst_n_in) q <= '1;
          else           q <= g_stage[g-1].q;
        end
      end
    end
    assign {d_hs, d_vs, d_bl} = g_stage[SYNC_DELAY-1].q;
  end

  // Priority chain built from the lowest-priority end: each layer either
  // claims the pixel (enabled and opaque) or passes through what lies below.
  logic [11:0] chain [NUM_LAYERS+1];
  assign chain[NUM_LAYERS] = BG_COLOR;

  for (genvar g = 0; g < NUM_LAYERS; g++) begin : g_layer
    logic [11:0] pix;
    assign pix      = layer_pixels_in[12*g +: 12];
    assign chain[g] = (mask[g] && (pix != '0)) ? pix : chain[g+1];
  end

  always_comb begin
    comp_rgb = chain[0];
    if (d_bl) comp_rgb = '0;
  end

  // Registered vsync is still high while the incoming delayed vsync is low.
  assign frame_edge = vsync_out & ~d_vs;

  always_ff @(posedge pixel_clk_in) begin
    if (!rst_n_in) begin
      hsync_out       <= 1'b1;
      vsync_out       <= 1'b1;
      blank_out       <= 1'b1;
      rgb_out         <= '0;
      frame_start_out <= 1'b0;
      frame_count_out <= '0;
      mask            <= '1;
    end else begin
      hsync_out       <= d_hs;
      vsync_out       <= d_vs;
      blank_out       <= d_bl;
      rgb_out         <= comp_rgb;
      frame_start_out <= frame_edge;
      if (frame_edge) begin
        frame_count_out <= frame_count_out + 16'd1;
        mask            <= layer_enable_in;
      end
    end
  end

endmodule

// File: tb/tb_sprite_compositor.sv
// Testbench for sprite_compositor. Two instances share one stimulus stream:
// dut0 with a 2-stage sync delay and dut1 with no delay stages. A behavioural
// model built from the per-cycle input history predicts every output of both
// instances on every cycle, and directed steps add explicit constant checks.
module tb_sprite_compositor;

  localparam logic [11:0] BG   = 12'h5A3;
  localparam int          MAXC = 4096;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        hs, vs, bl;
  logic [47:0] pix;
  logic [3:0]  en;

  logic        hs0, vs0, bl0, fs0;
  logic [11:0] rgb0;
  logic [15:0] cnt0;
  logic        hs1, vs1, bl1, fs1;
  logic [11:0] rgb1;
  logic [15:0] cnt1;

  always #5 clk = ~clk;

  sprite_compositor #(.NUM_LAYERS(4), .SYNC_DELAY(2), .BG_COLOR(BG)) dut0 (
    .pixel_clk_in(clk), .rst_n_in(rst_n), .hsync_in(hs), .vsync_in(vs),
    .blank_in(bl), .layer_pixels_in(pix), .layer_enable_in(en),
    .hsync_out(hs0), .vsync_out(vs0), .blank_out(bl0), .rgb_out(rgb0),
    .frame_start_out(fs0), .frame_count_out(cnt0));

  sprite_compositor #(.NUM_LAYERS(4), .SYNC_DELAY(0), .BG_COLOR(BG)) dut1 (
    .pixel_clk_in(clk), .rst_n_in(rst_n), .hsync_in(hs), .vsync_in(vs),
    .blank_in(bl), .layer_pixels_in(pix), .layer_enable_in(en),
    .hsync_out(hs1), .vsync_out(vs1), .blank_out(bl1), .rgb_out(rgb1),
    .frame_start_out(fs1), .frame_count_out(cnt1));

  // Input history, one entry per clock edge.
  logic        h_rst [MAXC];
  logic        h_hs  [MAXC];
  logic        h_vs  [MAXC];
  logic        h_bl  [MAXC];
  logic [47:0] h_pix [MAXC];
  logic [3:0]  h_en  [MAXC];
  int          cyc = 0;

  // Model state per instance.
  logic        m_vs   [2];
  logic [3:0]  m_mask [2];
  logic [15:0] m_cnt  [2];

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    assert (act === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h (edge %0d)", tag, act, exp, cyc);
    end
  endtask

  task automatic model_check(input int n, input int dly, input int k,
                             input logic a_hs, input logic a_vs, input logic a_bl,
                             input logic [11:0] a_rgb, input logic a_fs,
                             input logic [15:0] a_cnt);
    logic        dhs, dvs, dbl, fedge, e_hs, e_vs, e_bl, e_fs;
    logic [11:0] e_rgb, p;
    bit          idle;
    string       sfx;
    sfx = (n == 0) ? "_d2" : "_d0";
    // Delayed sync is the input from dly edges ago unless a reset edge
    // happened in between (or history does not reach back that far).
    idle = (k - dly) < 0;
    for (int j = k - dly; j < k; j++)
      if (j >= 0 && !h_rst[j]) idle = 1;
    if (idle) begin
      dhs = 1'b1; dvs = 1'b1; dbl = 1'b1;
    end else begin
      dhs = h_hs[k-dly]; dvs = h_vs[k-dly]; dbl = h_bl[k-dly];
    end
    if (!h_rst[k]) begin
      e_hs = 1'b1; e_vs = 1'b1; e_bl = 1'b1; e_rgb = 12'h000; e_fs = 1'b0;
      m_cnt[n] = 16'h0000; m_mask[n] = 4'hF; m_vs[n] = 1'b1;
    end else begin
      e_hs = dhs; e_vs = dvs; e_bl = dbl;
      e_rgb = BG;
      if (dbl) e_rgb = 12'h000;
      else
        for (int l = 3; l >= 0; l--) begin
          p = h_pix[k][12*l +: 12];
          if (m_mask[n][l] && p != 12'h000) e_rgb = p;
        end
      fedge = m_vs[n] & ~dvs;
      e_fs  = fedge;
      if (fedge) begin
        m_cnt[n]  = m_cnt[n] + 16'd1;
        m_mask[n] = h_en[k];
      end
      m_vs[n] = dvs;
    end
    chk({"hsync", sfx}, 16'(a_hs), 16'(e_hs));
    chk({"vsync", sfx}, 16'(a_vs), 16'(e_vs));
    chk({"blank", sfx}, 16'(a_bl), 16'(e_bl));
    chk({"rgb", sfx}, 16'(a_rgb), 16'(e_rgb));
    chk({"fstart", sfx}, 16'(a_fs), 16'(e_fs));
    chk({"fcount", sfx}, a_cnt, m_cnt[n]);
  endtask

  task automatic step();
    if (cyc >= MAXC) begin
      $display("FAIL cycle_budget: observed %0d edges expected < %0d", cyc, MAXC);
      $fatal(1, "cycle budget exhausted");
    end
    h_rst[cyc] = rst_n; h_hs[cyc] = hs; h_vs[cyc] = vs; h_bl[cyc] = bl;
    h_pix[cyc] = pix;   h_en[cyc] = en;
    @(posedge clk);
    #1;
    model_check(0, 2, cyc, hs0, vs0, bl0, rgb0, fs0, cnt0);
    model_check(1, 0, cyc, hs1, vs1, bl1, rgb1, fs1, cnt1);
    cyc++;
  endtask

  function automatic logic [47:0] rand_pix();
    logic [47:0] r;
    for (int l = 0; l < 4; l++)
      r[12*l +: 12] = ($urandom_range(0, 2) == 0) ? 12'h000 : 12'($urandom);
    return r;
  endfunction

  task automatic vsync_pulse();
    hs = 1'b1; bl = 1'b1; vs = 1'b0; step(); step();
    vs = 1'b1; step(); step();
  endtask

  task automatic rand_frame(input int n_active);
    vsync_pulse();
    for (int i = 0; i < n_active; i++) begin
      bl  = ($urandom_range(0, 9) == 0);
      hs  = ($urandom_range(0, 7) != 0);
      pix = rand_pix();
      if ($urandom_range(0, 5) == 0) en = 4'($urandom);
      step();
    end
    bl = 1'b1; hs = 1'b1; step(); step();
  endtask

  int fs_seen;
  logic [15:0] base_cnt;

  initial begin
    // Reset held for 3 edges while inputs toggle.
    rst_n = 1'b0; hs = 1'b0; vs = 1'b0; bl = 1'b0; pix = '0; en = 4'h0;
    for (int i = 0; i < 3; i++) begin
      hs = 1'($urandom); vs = 1'($urandom); bl = 1'($urandom);
      pix = rand_pix(); en = 4'($urandom);
      step();
      chk("rst_hsync", 16'(hs0), 16'h1);
      chk("rst_vsync", 16'(vs0), 16'h1);
      chk("rst_blank", 16'(bl0), 16'h1);
      chk("rst_rgb", 16'(rgb0), 16'h000);
      chk("rst_fstart", 16'(fs0), 16'h0);
      chk("rst_fcount", cnt0, 16'h0000);
    end
    rst_n = 1'b1; hs = 1'b1; vs = 1'b1; bl = 1'b1; pix = '0; en = 4'hF;
    for (int i = 0; i < 4; i++) step();

    // Latency: blank low for one edge, layer-0 pixel two edges later.
    bl = 1'b0; step();
    bl = 1'b1; step();
    chk("lat_blank_early", 16'(bl0), 16'h1);
    pix = {36'h0, 12'hF00}; step();
    chk("lat_blank_low", 16'(bl0), 16'h0);
    chk("lat_rgb", 16'(rgb0), 16'hF00);
    pix = '0; step();
    chk("lat_blank_high", 16'(bl0), 16'h1);

    // Undelayed build: hsync low appears after one edge.
    hs = 1'b0; step();
    chk("d0_hsync_low", 16'(hs1), 16'h0);
    chk("d2_hsync_still_high", 16'(hs0), 16'h1);
    hs = 1'b1; step(); step(); step();

    // Priority with mask 1111 in the active area.
    bl = 1'b0; pix = {12'h0AB, 12'h00F, 12'h0F0, 12'h000};
    step(); step(); step();
    chk("prio_layer1", 16'(rgb0), 16'h0F0);
    pix = '0; step();
    chk("prio_bg", 16'(rgb0), 16'(BG));
    bl = 1'b1; pix = {12'h111, 12'h222, 12'h333, 12'h444};
    step(); step(); step();
    chk("prio_blanked", 16'(rgb0), 16'h000);

    // Randomized frames, including mid-frame enable changes.
    for (int f = 0; f < 6; f++) rand_frame(24);

    // Reset in the middle of an active area.
    vsync_pulse();
    bl = 1'b0;
    for (int i = 0; i < 5; i++) begin pix = rand_pix(); step(); end
    rst_n = 1'b0; step();
    chk("midrst_blank", 16'(bl0), 16'h1);
    chk("midrst_fcount", cnt0, 16'h0000);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin pix = rand_pix(); step(); end
    bl = 1'b1; step(); step();

    // Mask shadowing: enable change mid-frame takes effect next frame.
    en = 4'hF; vsync_pulse();
    bl = 1'b0; pix = {12'h000, 12'h000, 12'h0F0, 12'h000};
    step(); step(); step();
    en = 4'b1101;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("shadow_hold", 16'(rgb0), 16'h0F0);
    end
    bl = 1'b1; step(); step();
    vsync_pulse();
    bl = 1'b0; step(); step(); step();
    chk("shadow_next_frame", 16'(rgb0), 16'(BG));
    bl = 1'b1; step(); step();

    // Frame counter: exactly three one-cycle pulses.
    base_cnt = cnt0;
    fs_seen  = 0;
    for (int p = 0; p < 3; p++) begin
      vs = 1'b0;
      for (int i = 0; i < 2; i++) begin step(); if (fs0) fs_seen++; end
      vs = 1'b1;
      for (int i = 0; i < 4; i++) begin step(); if (fs0) fs_seen++; end
    end
    chk("fstart_pulses", 16'(fs_seen), 16'd3);
    chk("fcount_plus3", cnt0, base_cnt + 16'd3);

    // Counter wrap from a forced 16'hFFFF.
    force dut0.frame_count_out = 16'hFFFF;
    force dut1.frame_count_out = 16'hFFFF;
    #1;
    release dut0.frame_count_out;
    release dut1.frame_count_out;
    m_cnt[0] = 16'hFFFF;
    m_cnt[1] = 16'hFFFF;
    vsync_pulse(); step();
    chk("wrap_d2", cnt0, 16'h0000);
    chk("wrap_d0", cnt1, 16'h0000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
